// File: rtl/mul_long_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MLA and UMULL/SMULL/UMLAL/SMLAL.
// Drives the dual write ports of the register file: RdLo on port 3, RdHi on port 4.
module mul_long_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_long,
  input  logic             sgn,
  input  logic             acc,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [AW-1:0]    rd_lo,
  input  logic [AW-1:0]    rd_hi,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             we3,
  output logic             long,
  output logic [AW-1:0]    a3,
  output logic [AW-1:0]    a4,
  output logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] wd4
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = 1;
  localparam logic [PW-1:0]    ONE_P = 1;
  localparam logic [AW-1:0]    PC_ADDR = '1;
  localparam logic [5:0]       LAST_ITER = 6'd31;

  typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    prod_q;
  logic             neg_q;
  logic             acc_q;
  logic             is_long_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [AW-1:0]    rd_lo_q;
  logic [AW-1:0]    rd_hi_q;

  logic             busy_q;
  logic             done_q;
  logic             illegal_q;
  logic             we3_q;
  logic             long_q;
  logic [AW-1:0]    a3_q;
  logic [AW-1:0]    a4_q;
  logic [WIDTH-1:0] wd3_q;
  logic [WIDTH-1:0] wd4_q;

  logic             signed_d;
  logic [WIDTH-1:0] mag_a_d;
  logic [WIDTH-1:0] mag_b_d;
  logic [PW-1:0]    prod_d;
  logic [PW-1:0]    acc_word_d;
  logic [PW-1:0]    fix_d;
  logic             bad_d;

  // Magnitudes for signed long multiplies; 0x80000000 negates to itself and is
  // then read as an unsigned magnitude, which is exactly what we want.
  always_comb begin
    signed_d = is_long && sgn;
    mag_a_d  = src_a;
    mag_b_d  = src_b;
    if (signed_d && src_a[WIDTH-1]) mag_a_d = ~src_a + ONE_W;
    if (signed_d && src_b[WIDTH-1]) mag_b_d = ~src_b + ONE_W;
  end

  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) prod_d = prod_q + mcand_q;
  end

  // Sign restore then accumulate; the carry out of the top bit falls away.
  always_comb begin
    acc_word_d = {(is_long_q ? acc_hi_q : {WIDTH{1'b0}}), acc_lo_q};
    fix_d      = prod_q;
    if (neg_q) fix_d = ~prod_q + ONE_P;
    if (acc_q) fix_d = fix_d + acc_word_d;
    bad_d = (rd_lo_q == PC_ADDR) || (is_long_q && (rd_hi_q == PC_ADDR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      neg_q     <= 1'b0;
      acc_q     <= 1'b0;
      is_long_q <= 1'b0;
      acc_lo_q  <= '0;
      acc_hi_q  <= '0;
      rd_lo_q   <= '0;
      rd_hi_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      we3_q     <= 1'b0;
      long_q    <= 1'b0;
      a3_q      <= '0;
      a4_q      <= '0;
      wd3_q     <= '0;
      wd4_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            mcand_q   <= {{WIDTH{1'b0}}, mag_a_d};
            mplier_q  <= mag_b_d;
            prod_q    <= '0;
            neg_q     <= signed_d && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            acc_q     <= acc;
            is_long_q <= is_long;
            acc_lo_q  <= acc_lo;
            acc_hi_q  <= acc_hi;
            rd_lo_q   <= rd_lo;
            rd_hi_q   <= rd_hi;
          end
        end
        CALC: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        // Outputs are loaded here so they are visible throughout the WB cycle.
        FIX: begin
          state_q   <= WB;
          prod_q    <= fix_d;
          a3_q      <= rd_lo_q;
          a4_q      <= rd_hi_q;
          wd3_q     <= fix_d[WIDTH-1:0];
          wd4_q     <= fix_d[PW-1:WIDTH];
          done_q    <= 1'b1;
          illegal_q <= bad_d;
          we3_q     <= !bad_d;
          long_q    <= is_long_q && !bad_d;
        end
        WB: begin
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          we3_q     <= 1'b0;
          long_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign we3     = we3_q;
  assign long    = long_q;
  assign a3      = a3_q;
  assign a4      = a4_q;
  assign wd3     = wd3_q;
  assign wd4     = wd4_q;

endmodule
